// File: rtl/wr_control_pkg.sv
// Shared definitions for the systolic array write controller.
//  - Default array dimension and per-lane address width, shared with the
//    read controller and the output memory array.
//  - Controller state type.
package wr_control_pkg;

    localparam int DEFAULT_WIDTH_HEIGHT = 16;
    localparam int DEFAULT_ADDR_W       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } wr_state_e;

endpackage

// File: rtl/wr_control_if.sv
// Handshake / write bus between the write controller and its neighbours.
//  active     : start request (from the read controller)
//  base_addr  : start address, common to all lanes
//  wr_en      : per-lane write enable, bit i = lane/column i
//  wr_addr    : per-lane address, lane i = [ADDR_W*i +: ADDR_W]
//  busy       : operation in progress
//  done       : one-cycle completion pulse
// master = controller side, slave = requester / memory side.
interface wr_control_if
    import wr_control_pkg::*;
#(
    parameter int WIDTH_HEIGHT = DEFAULT_WIDTH_HEIGHT,
    parameter int ADDR_W       = DEFAULT_ADDR_W
) ();

    logic                           active;
    logic [ADDR_W-1:0]              base_addr;
    logic [WIDTH_HEIGHT-1:0]        wr_en;
    logic [ADDR_W*WIDTH_HEIGHT-1:0] wr_addr;
    logic                           busy;
    logic                           done;

    modport master (
        input  active,
        input  base_addr,
        output wr_en,
        output wr_addr,
        output busy,
        output done
    );

    modport slave (
        output active,
        output base_addr,
        input  wr_en,
        input  wr_addr,
        input  busy,
        input  done
    );

endinterface

// File: rtl/wr_control_lane_addr.sv
// Per-lane address register for the output memory.
//  clk       : clock
//  reset     : asynchronous active-low reset (clears addr to 0)
//  load      : load base_addr (start of an operation)
//  inc       : advance addr by one (lane wrote this cycle); wraps silently
//  base_addr : start address
//  addr      : current lane address
module wr_control_lane_addr #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (load) begin
            addr <= base_addr;
        end else if (inc) begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/wr_control.sv
// Write-side controller for the systolic array output memory.
// On a start request it raises per-lane write enables on a diagonal
// wavefront (lane i starts i cycles after lane 0, each lane stays enabled
// for WIDTH_HEIGHT cycles) and steps each lane's address once per write,
// then pulses done for one cycle.
//  clk   : clock, all state on posedge
//  reset : asynchronous active-low reset
//  bus   : wr_control_if master (active, base_addr in; wr_en, wr_addr,
//          busy, done out, all registered)
module wr_control
    import wr_control_pkg::*;
#(
    parameter int WIDTH_HEIGHT = DEFAULT_WIDTH_HEIGHT,
    parameter int ADDR_W       = DEFAULT_ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    wr_control_if.master bus
);

    localparam int COUNT_W = $clog2(2 * WIDTH_HEIGHT);

    wr_state_e                      state_reg, state_next;
    logic [WIDTH_HEIGHT-1:0]        wr_en_reg, wr_en_next;
    logic [COUNT_W-1:0]             count_reg, count_next;
    logic                           busy_reg, busy_next;
    logic                           done_reg, done_next;
    logic                           load_addr;
    logic                           step_addr;
    logic                           lower_empty;
    logic [ADDR_W*WIDTH_HEIGHT-1:0] wr_addr_flat;

    // Only the top lane still enabled: the next drain shift empties wr_en.
    assign lower_empty = (wr_en_reg[WIDTH_HEIGHT-2:0] == '0);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            wr_en_reg <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= wr_en_next;
            count_reg <= count_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.active)  state_next = RAMP;
            RAMP:    if (&wr_en_reg)  state_next = DRAIN;
            DRAIN:   if (lower_empty) state_next = FINISH;
            FINISH:                   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Output next-values; FINISH falls through to the all-idle defaults.
    always_comb begin
        wr_en_next = '0;
        count_next = '0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        load_addr  = 1'b0;
        step_addr  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.active) begin
                    wr_en_next = WIDTH_HEIGHT'(1);
                    busy_next  = 1'b1;
                    load_addr  = 1'b1;
                end
            end
            RAMP: begin
                // Keep filling with ones until every lane is on, then start draining.
                wr_en_next = {wr_en_reg[WIDTH_HEIGHT-2:0], ~(&wr_en_reg)};
                count_next = count_reg + COUNT_W'(1);
                busy_next  = 1'b1;
                step_addr  = 1'b1;
            end
            DRAIN: begin
                wr_en_next = {wr_en_reg[WIDTH_HEIGHT-2:0], 1'b0};
                count_next = count_reg + COUNT_W'(1);
                busy_next  = 1'b1;
                done_next  = lower_empty;
                step_addr  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // One address register per lane; a lane advances on each cycle it writes.
    for (genvar gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_lane
        wr_control_lane_addr #(
            .ADDR_W(ADDR_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (load_addr),
            .inc       (step_addr & wr_en_reg[gi]),
            .base_addr (bus.base_addr),
            .addr      (wr_addr_flat[gi*ADDR_W +: ADDR_W])
        );
    end

    assign bus.wr_en   = wr_en_reg;
    assign bus.wr_addr = wr_addr_flat;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;

    // The wavefront lasts 2*WIDTH_HEIGHT-1 counted edges; more means the FSM ran away.
    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        int'(count_reg) <= 2 * WIDTH_HEIGHT);
    a_finish_count: assert property (@(posedge clk) disable iff (!reset)
        (state_reg == FINISH) |-> (int'(count_reg) == 2 * WIDTH_HEIGHT - 1));

endmodule

// File: tb/tb_wr_control.sv
// Testbench for wr_control: randomized operations checked each cycle against
// a wavefront model (lane i writes during cycles i+1..i+WH after start,
// k-th write at base+k, done in cycle 2*WH).
module tb_wr_control;

    localparam int WH  = 16;
    localparam int WHB = 4;
    localparam int AW  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wr_control_if #(.WIDTH_HEIGHT(WH),  .ADDR_W(AW)) bus_a ();
    wr_control_if #(.WIDTH_HEIGHT(WHB), .ADDR_W(AW)) bus_b ();

    wr_control #(.WIDTH_HEIGHT(WH), .ADDR_W(AW)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    wr_control #(.WIDTH_HEIGHT(WHB), .ADDR_W(AW)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Enable pattern in cycle n (n=1 is the cycle right after the start edge).
    function automatic logic [15:0] model_en(int n, int wh);
        logic [15:0] v = '0;
        for (int i = 0; i < wh; i++)
            if ((n - 1 >= i) && (n - 1 < i + wh)) v[i] = 1'b1;
        return v;
    endfunction

    // Lane addresses in cycle n: base plus the number of writes already done.
    function automatic logic [127:0] model_addr(int n, int wh, logic [7:0] base);
        logic [127:0] v = '0;
        for (int i = 0; i < wh; i++) begin
            int k = n - 1 - i;
            if (k < 0)  k = 0;
            if (k > wh) k = wh;
            v[8*i +: 8] = base + 8'(k);
        end
        return v;
    endfunction

    task automatic test_reset();
        bus_a.active = 1'b0; bus_a.base_addr = 8'h00;
        bus_b.active = 1'b0; bus_b.base_addr = 8'h00;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.wr_en !== 16'h0) begin errors++; $display("FAIL reset_wr_en got %h exp 0000", bus_a.wr_en); end
        checks++; if (bus_a.wr_addr !== 128'h0) begin errors++; $display("FAIL reset_wr_addr got %h exp 0", bus_a.wr_addr); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus_a.busy); end
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus_a.done); end
        checks++; if (bus_b.wr_en !== 4'h0) begin errors++; $display("FAIL reset_b_wr_en got %h exp 0", bus_b.wr_en); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.busy !== 1'b0 || bus_a.wr_en !== 16'h0) begin
            errors++; $display("FAIL idle_hold busy=%b wr_en=%h exp 0/0000", bus_a.busy, bus_a.wr_en);
        end
        $display("reset: outputs cleared, idle held with active low");
    endtask

    // Single operations; later ones wiggle active/base_addr while busy.
    task automatic test_single_ops();
        logic [7:0] bases [6];
        bases[0] = 8'h00; bases[1] = 8'h10; bases[2] = 8'hF8;
        for (int j = 3; j < 6; j++) bases[j] = 8'($urandom);
        for (int j = 0; j < 6; j++) begin
            logic [7:0] b = bases[j];
            int errs0 = errors;
            bus_a.active = 1'b1; bus_a.base_addr = b;
            for (int n = 1; n <= 2 * WH; n++) begin
                @(negedge clk);
                checks++; if (bus_a.wr_en !== model_en(n, WH)) begin
                    errors++; $display("FAIL op_wr_en base=%h cycle %0d got %h exp %h", b, n, bus_a.wr_en, model_en(n, WH));
                end
                checks++; if (bus_a.wr_addr !== model_addr(n, WH, b)) begin
                    errors++; $display("FAIL op_wr_addr base=%h cycle %0d got %h exp %h", b, n, bus_a.wr_addr, model_addr(n, WH, b));
                end
                checks++; if (bus_a.busy !== 1'b1) begin
                    errors++; $display("FAIL op_busy base=%h cycle %0d got %b exp 1", b, n, bus_a.busy);
                end
                checks++; if (bus_a.done !== (n == 2 * WH)) begin
                    errors++; $display("FAIL op_done base=%h cycle %0d got %b exp %b", b, n, bus_a.done, (n == 2 * WH));
                end
                if (j >= 3 && n < 2 * WH) begin
                    bus_a.active    = 1'($urandom_range(0, 1));
                    bus_a.base_addr = 8'($urandom);
                end else begin
                    bus_a.active = 1'b0;
                end
            end
            @(negedge clk);
            checks++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.wr_en !== 16'h0) begin
                errors++; $display("FAIL op_idle base=%h busy=%b done=%b wr_en=%h exp 0/0/0000", b, bus_a.busy, bus_a.done, bus_a.wr_en);
            end
            checks++; if (bus_a.wr_addr !== model_addr(2 * WH, WH, b)) begin
                errors++; $display("FAIL op_final_addr base=%h got %h exp %h", b, bus_a.wr_addr, model_addr(2 * WH, WH, b));
            end
            $display("op: base=%02h lane0 first=%02h final=%02h errors_this_op=%0d", b, b, 8'(b + 8'(WH)), errors - errs0);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] b = 8'($urandom);
        bus_a.active = 1'b1; bus_a.base_addr = b;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            bus_a.active = 1'b0;
            checks++; if (bus_a.wr_en !== model_en(n, WH)) begin
                errors++; $display("FAIL pre_reset_wr_en cycle %0d got %h exp %h", n, bus_a.wr_en, model_en(n, WH));
            end
        end
        reset = 1'b0;
        #1;
        checks++; if (bus_a.wr_en !== 16'h0) begin errors++; $display("FAIL async_wr_en got %h exp 0000", bus_a.wr_en); end
        checks++; if (bus_a.wr_addr !== 128'h0) begin errors++; $display("FAIL async_wr_addr got %h exp 0", bus_a.wr_addr); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", bus_a.busy); end
        bus_a.active = 1'b1;
        repeat (2) @(negedge clk);
        bus_a.active = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 4 * WH; c++) begin
            @(negedge clk);
            checks++; if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
                errors++; $display("FAIL post_reset_quiet cycle %0d done=%b busy=%b exp 0/0", c, bus_a.done, bus_a.busy);
            end
        end
        b = 8'($urandom);
        bus_a.active = 1'b1; bus_a.base_addr = b;
        for (int n = 1; n <= 2 * WH; n++) begin
            @(negedge clk);
            bus_a.active = 1'b0;
            checks++; if (bus_a.wr_en !== model_en(n, WH) || bus_a.wr_addr !== model_addr(n, WH, b) || bus_a.done !== (n == 2 * WH)) begin
                errors++; $display("FAIL restart cycle %0d wr_en=%h exp %h done=%b exp %b addr=%h exp %h", n, bus_a.wr_en,
                                   model_en(n, WH), bus_a.done, (n == 2 * WH), bus_a.wr_addr, model_addr(n, WH, b));
            end
        end
        @(negedge clk);
        $display("reset_mid_op: cleared at cycle 10, clean restart base=%02h", b);
    endtask

    // active held high: ops repeat every 2*WH+1 cycles with one idle cycle between.
    task automatic test_back_to_back();
        localparam int PERIOD = 2 * WH + 1;
        logic [7:0] lat  = 8'($urandom);
        logic [7:0] next_b = lat;
        int ops = 0;
        bus_a.active = 1'b1; bus_a.base_addr = lat;
        for (int t = 1; t <= 3 * PERIOD; t++) begin
            int n = ((t - 1) % PERIOD) + 1;
            logic [7:0] b;
            @(negedge clk);
            if (n == 1) lat = next_b;
            if (n == PERIOD) begin
                checks++; if (bus_a.busy !== 1'b0 || bus_a.wr_en !== 16'h0 || bus_a.done !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle t=%0d busy=%b wr_en=%h done=%b exp 0/0000/0", t, bus_a.busy, bus_a.wr_en, bus_a.done);
                end
                ops++;
                $display("b2b: op %0d base=%02h complete", ops, lat);
            end else begin
                checks++; if (bus_a.wr_en !== model_en(n, WH) || bus_a.busy !== 1'b1 || bus_a.done !== (n == 2 * WH)) begin
                    errors++; $display("FAIL b2b t=%0d n=%0d wr_en=%h exp %h busy=%b done=%b exp %b", t, n, bus_a.wr_en,
                                       model_en(n, WH), bus_a.busy, bus_a.done, (n == 2 * WH));
                end
                checks++; if (bus_a.wr_addr !== model_addr(n, WH, lat)) begin
                    errors++; $display("FAIL b2b_addr t=%0d got %h exp %h", t, bus_a.wr_addr, model_addr(n, WH, lat));
                end
            end
            b = 8'($urandom);
            bus_a.base_addr = b;
            if (n == PERIOD) next_b = b;
            if (t == 3 * PERIOD) bus_a.active = 1'b0;
        end
        @(negedge clk);
        checks++; if (bus_a.busy !== 1'b0 || bus_a.wr_en !== 16'h0) begin
            errors++; $display("FAIL b2b_stop busy=%b wr_en=%h exp 0/0000", bus_a.busy, bus_a.wr_en);
        end
    endtask

    task automatic test_wh4();
        logic [7:0] b = 8'($urandom);
        logic [127:0] ea;
        logic [15:0] ee;
        bus_b.active = 1'b1; bus_b.base_addr = b;
        for (int n = 1; n <= 2 * WHB; n++) begin
            @(negedge clk);
            bus_b.active = 1'b0;
            bus_b.base_addr = 8'($urandom);
            ee = model_en(n, WHB);
            ea = model_addr(n, WHB, b);
            checks++; if (bus_b.wr_en !== ee[3:0]) begin
                errors++; $display("FAIL wh4_wr_en cycle %0d got %h exp %h", n, bus_b.wr_en, ee[3:0]);
            end
            checks++; if (bus_b.wr_addr !== ea[31:0]) begin
                errors++; $display("FAIL wh4_wr_addr cycle %0d got %h exp %h", n, bus_b.wr_addr, ea[31:0]);
            end
            checks++; if (bus_b.done !== (n == 2 * WHB) || bus_b.busy !== 1'b1) begin
                errors++; $display("FAIL wh4_done cycle %0d done=%b exp %b busy=%b exp 1", n, bus_b.done, (n == 2 * WHB), bus_b.busy);
            end
        end
        @(negedge clk);
        checks++; if (bus_b.busy !== 1'b0 || bus_b.done !== 1'b0) begin
            errors++; $display("FAIL wh4_idle busy=%b done=%b exp 0/0", bus_b.busy, bus_b.done);
        end
        $display("wh4: base=%02h op complete", b);
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_reset_mid_op();
        test_back_to_back();
        test_wh4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
